product_accumulator: RTL

- Downstream consumer of the 4x4 array multiplier's 8-bit product.
- Accepts products over a valid/ready handshake and sums them in a saturating accumulator. It also counts the accepted samples.
- On a dump request it drains a byte-serial frame (sample count, then accumulator bytes LSB first) to the output pins, then clears itself for the next batch.

---
 rtl/product_accumulator_pkg.sv | 17 +
 rtl/product_accumulator_sat_add.sv | 19 +
 rtl/product_accumulator.sv | 118 +++++++++++
 3 files changed

// File: rtl/product_accumulator_pkg.sv
// Shared types and constants for the product accumulator and its adder.
package product_accumulator_pkg;

   typedef enum logic {ACCUM, DRAIN} state_t;

   localparam int PROD_W        = 8;
   localparam int DEFAULT_ACC_W = 16;

   // A frame is the count byte followed by every accumulator byte.
   function automatic int frame_bytes(input int acc_w);
      return 1 + acc_w / 8;
   endfunction

   localparam int FRAME_BYTES = frame_bytes(DEFAULT_ACC_W);
   localparam int IDX_W       = $clog2(FRAME_BYTES);

endpackage

// File: rtl/product_accumulator_sat_add.sv
// Unsigned W-bit plus product-width saturating adder.
module sat_add
   import product_accumulator_pkg::*;
#(
   parameter int W = 16
) (
   input  logic [W-1:0]      a,
   input  logic [PROD_W-1:0] b,
   output logic [W-1:0]      sum,
   output logic              ovf
);

   logic [W:0] full;

   assign full = {1'b0, a} + {{(W + 1 - PROD_W){1'b0}}, b};
   assign ovf  = full[W];
   assign sum  = ovf ? '1 : full[W-1:0];

endmodule

// File: rtl/product_accumulator.sv
// Saturating product accumulator that drains a byte-serial frame on dump.
//  state | meaning
//  ACCUM | accepting products into acc / sample_cnt
//  DRAIN | presenting count byte then acc bytes LSB first, then self-clear
module product_accumulator
   import product_accumulator_pkg::*;
#(
   parameter int ACC_W = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_product,
   input  logic             dump,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_data,
   output logic             out_last,
   output logic             acc_ovf,
   output logic [CNT_W-1:0] sample_cnt,
   output logic             busy
);

   localparam int FB = frame_bytes(ACC_W);
   localparam int IW = $clog2(FB);

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [IW-1:0]    idx;
   logic [IW-1:0]    idx_nxt;
   logic             accept;
   logic [ACC_W-1:0] acc_sum;
   logic             acc_sat;
   logic [CNT_W-1:0] cnt_sum;
   logic             cnt_sat;
   logic [7:0]       frame_b [FB];

   assign in_ready = (state == ACCUM);
   assign accept   = in_valid & in_ready;
   assign idx_nxt  = idx + IW'(1);

   always_comb begin
      frame_b[0] = sample_cnt;
      for (int k = 1; k < FB; k++) begin
         frame_b[k] = acc[(k - 1) * 8 +: 8];
      end
   end

   sat_add #(.W(ACC_W)) u_acc_add (
      .a   (acc),
      .b   (in_product),
      .sum (acc_sum),
      .ovf (acc_sat)
   );

   sat_add #(.W(CNT_W)) u_cnt_add (
      .a   (sample_cnt),
      .b   (8'd1),
      .sum (cnt_sum),
      .ovf (cnt_sat)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ACCUM;
         acc        <= '0;
         sample_cnt <= '0;
         acc_ovf    <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= 8'h00;
         out_last   <= 1'b0;
         busy       <= 1'b0;
         idx        <= '0;
      end else begin
         case (state)
            ACCUM: begin
               if (accept) begin
                  acc <= acc_sum;
                  if (!cnt_sat) sample_cnt <= cnt_sum;
                  if (acc_sat) acc_ovf <= 1'b1;
               end
               if (dump) begin
                  state <= DRAIN;
                  busy  <= 1'b1;
                  idx   <= '0;
               end
            end
            DRAIN: begin
               // acc and sample_cnt are frozen here, so they serve as the snapshot.
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  out_data  <= frame_b[0];
                  out_last  <= 1'b0;
               end else if (out_ready) begin
                  if (out_last) begin
                     out_valid  <= 1'b0;
                     out_last   <= 1'b0;
                     out_data   <= 8'h00;
                     acc        <= '0;
                     sample_cnt <= '0;
                     acc_ovf    <= 1'b0;
                     busy       <= 1'b0;
                     idx        <= '0;
                     state      <= ACCUM;
                  end else begin
                     idx      <= idx_nxt;
                     out_data <= frame_b[idx_nxt];
                     out_last <= (idx_nxt == IW'(FB - 1));
                  end
               end
            end
         endcase
      end
   end

endmodule
